// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath slice.
//   fetch_state_t : fetch controller states (RUN, HALT, FAULT)
//   INSTR_W/BYTE_W: instruction and memory byte widths
//   ADDR_W        : width of the address fields stored in the IF/ID register
//   if_id_t       : IF/ID pipeline register contents
//   word_aligned  : true when the two low address bits select a word boundary
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int BYTE_W  = 8;
  localparam int ADDR_W  = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               valid;
  } if_id_t;

  function automatic logic word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/imem_word_read.sv
// Combinational little-endian word read from a byte-array memory.
//   imem_bytes : memory contents, byte i at imem_bytes[i]
//   addr       : byte address of the word
//   word       : {imem[addr+3], imem[addr+2], imem[addr+1], imem[addr]}
//   in_range   : addr <= MEM_BYTES-4 (whole word lies inside the memory)
// When addr is out of range the byte index is forced to 0 so no read
// ever reaches past the last byte; word is then meaningless.
module imem_word_read
  import mips_pkg::*;
#(
  parameter int MEM_BYTES = 48,
  parameter int PC_W      = 32
) (
  input  logic [MEM_BYTES-1:0][BYTE_W-1:0] imem_bytes,
  input  logic [PC_W-1:0]                  addr,
  output logic [INSTR_W-1:0]               word,
  output logic                             in_range
);

  localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  logic [IDX_W-1:0] base;

  // Range check, safe base index and byte assembly.
  always_comb begin
    in_range = (addr <= PC_W'(MEM_BYTES - 4));
    if (in_range) begin
      base = addr[IDX_W-1:0];
    end else begin
      base = '0;
    end
    word = {imem_bytes[base + IDX_W'(3)],
            imem_bytes[base + IDX_W'(2)],
            imem_bytes[base + IDX_W'(1)],
            imem_bytes[base]};
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage of the monocycle MIPS datapath.
//   clk, reset      : clock, synchronous active-high reset
//   imem_bytes      : instruction ROM bytes (little-endian words)
//   stall           : freeze PC and IF/ID register
//   redirect_en/redirect_target : taken branch/jump to a byte address
//   instr, instr_pc, pc_plus4, valid : IF/ID register
//   done            : PC ran past the ROM end (cleared by reset or redirect)
//   fault           : misaligned redirect seen (cleared only by reset)
// Per-edge priority: reset > redirect > stall > normal fetch.
// PC_W must not exceed mips_pkg::ADDR_W.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int MEM_BYTES = 48,
  parameter int PC_W      = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [MEM_BYTES-1:0][BYTE_W-1:0] imem_bytes,
  input  logic                             stall,
  input  logic                             redirect_en,
  input  logic [PC_W-1:0]                  redirect_target,
  output logic [INSTR_W-1:0]               instr,
  output logic [PC_W-1:0]                  instr_pc,
  output logic [PC_W-1:0]                  pc_plus4,
  output logic                             valid,
  output logic                             done,
  output logic                             fault
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    pc_next;
  if_id_t             out_q, out_d;
  logic               done_q, done_d;
  logic               fault_q, fault_d;
  logic [INSTR_W-1:0] rom_word;
  logic               rom_in_range;

  imem_word_read #(
    .MEM_BYTES (MEM_BYTES),
    .PC_W      (PC_W)
  ) u_word_read (
    .imem_bytes (imem_bytes),
    .addr       (pc_q),
    .word       (rom_word),
    .in_range   (rom_in_range)
  );

  assign pc_next = pc_q + PC_W'(4);

  // Next-state, next-PC and IF/ID register contents.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    done_d  = done_q;
    fault_d = fault_q;
    case (state_q)
      RUN: begin
        if (redirect_en) begin
          // The word fetched on this edge belongs to the wrong path.
          out_d.valid = 1'b0;
          if (word_aligned(redirect_target[1:0])) begin
            pc_d = redirect_target;
          end else begin
            state_d = FAULT;
            fault_d = 1'b1;
            done_d  = 1'b0;
          end
        end else if (stall) begin
          state_d = RUN;
        end else if (rom_in_range) begin
          out_d.instr    = rom_word;
          out_d.pc       = ADDR_W'(pc_q);
          out_d.pc_plus4 = ADDR_W'(pc_next);
          out_d.valid    = 1'b1;
          pc_d           = pc_next;
        end else begin
          state_d     = HALT;
          out_d.valid = 1'b0;
          done_d      = 1'b1;
        end
      end
      HALT: begin
        // Leaving HALT lets a backward branch from the last word restart fetch.
        if (redirect_en) begin
          done_d = 1'b0;
          if (word_aligned(redirect_target[1:0])) begin
            pc_d    = redirect_target;
            state_d = RUN;
          end else begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end else begin
          state_d = HALT;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d     = FAULT;
        out_d.valid = 1'b0;
        done_d      = 1'b0;
        fault_d     = 1'b1;
      end
    endcase
  end

  // State, PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

  assign instr    = out_q.instr;
  assign instr_pc = out_q.pc[PC_W-1:0];
  assign pc_plus4 = out_q.pc_plus4[PC_W-1:0];
  assign valid    = out_q.valid;
  assign done     = done_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam int MEM_BYTES = 48;
  localparam int PC_W      = 32;
  localparam int NWORDS    = MEM_BYTES / 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [MEM_BYTES-1:0][7:0]   imem;
  logic                        stall;
  logic                        redirect_en;
  logic [PC_W-1:0]             redirect_target;
  logic [31:0]                 instr;
  logic [PC_W-1:0]             instr_pc;
  logic [PC_W-1:0]             pc_plus4;
  logic                        valid;
  logic                        done;
  logic                        fault;

  fetch_stage #(.MEM_BYTES(MEM_BYTES), .PC_W(PC_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_bytes      (imem),
    .stall           (stall),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .pc_plus4        (pc_plus4),
    .valid           (valid),
    .done            (done),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] romw [NWORDS];

  typedef struct {
    logic        rst;
    logic        stl;
    logic        red;
    logic [31:0] tgt;
    logic        v;
    logic        d;
    logic        f;
    logic        chk;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
  } vec_t;

  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < NWORDS; i++)
      for (int b = 0; b < 4; b++)
        imem[4*i+b] = romw[i][8*b +: 8];
  endtask

  function automatic void add(input logic rst, input logic stl, input logic red,
                              input logic [31:0] tgt, input logic v, input logic d,
                              input logic f, input logic chk, input logic [31:0] ins,
                              input logic [31:0] pc, input logic [31:0] pc4);
    vec_t r;
    r.rst = rst; r.stl = stl; r.red = red; r.tgt = tgt;
    r.v = v; r.d = d; r.f = f; r.chk = chk; r.ins = ins; r.pc = pc; r.pc4 = pc4;
    tbl.push_back(r);
  endfunction

  // free-running fetch expected to deliver word ins at byte address pc
  function automatic void fr(input logic [31:0] ins, input logic [31:0] pc);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, ins, pc, pc + 32'd4);
  endfunction

  function automatic void rs();
    add(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'd0);
  endfunction

  task automatic drive(input logic rst, input logic stl, input logic red, input logic [31:0] tgt);
    reset = rst; stall = stl; redirect_en = red; redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  // reference model: program counter plus halted/faulted flags
  logic [31:0] m_pc;
  bit          m_halted, m_faulted, m_chk;
  logic [31:0] e_ins, e_pc, e_pc4;
  bit          e_valid;

  task automatic model_step(input logic rst, input logic stl, input logic red, input logic [31:0] tgt);
    m_chk = 1'b0;
    if (rst) begin
      m_pc = 0; m_halted = 0; m_faulted = 0;
      e_ins = 0; e_pc = 0; e_pc4 = 0; e_valid = 0; m_chk = 1'b1;
    end else if (m_faulted) begin
      e_valid = 0;
    end else if (red) begin
      e_valid = 0;
      m_halted = 0;
      if (tgt % 4 != 0) m_faulted = 1;
      else m_pc = tgt;
    end else if (m_halted || stl) begin
      // nothing moves
    end else if (m_pc <= MEM_BYTES - 4) begin
      e_ins = romw[m_pc / 4]; e_pc = m_pc; e_pc4 = m_pc + 4; e_valid = 1;
      m_pc = m_pc + 4;
    end else begin
      m_halted = 1; e_valid = 0;
    end
    if (e_valid) m_chk = 1'b1;
  endtask

  initial begin
    romw[0]  = 32'h80010028; romw[1]  = 32'h80020014; romw[2]  = 32'h80030023;
    romw[3]  = 32'h80040038; romw[4]  = 32'h00221820; romw[5]  = 32'h00642024;
    romw[6]  = 32'h00A63025; romw[7]  = 32'h8C140002; romw[8]  = 32'hAC150004;
    romw[9]  = 32'h0023B022; romw[10] = 32'h0356B020; romw[11] = 32'h1282FFFD;
    load_rom();

    // T1: reset then 12 fetches, then end of program
    rs();
    fr(32'h80010028, 32'd0);
    for (int k = 1; k < 11; k++) fr(romw[k], 32'(4*k));
    fr(32'h1282FFFD, 32'd44);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    // T3: stall ignored in HALT, backward branch to 36 restarts fetch
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, 1'b0, 1'b1, 32'd36, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    fr(32'h0023B022, 32'd36);
    fr(32'h0356B020, 32'd40);
    fr(32'h1282FFFD, 32'd44);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    // T2: stall for 3 cycles at pc 8
    rs();
    fr(32'h80010028, 32'd0);
    fr(32'h80020014, 32'd4);
    fr(32'h80030023, 32'd8);
    for (int k = 0; k < 3; k++)
      add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80030023, 32'd8, 32'd12);
    fr(32'h80040038, 32'd12);
    fr(romw[4], 32'd16);
    fr(romw[5], 32'd20);
    // T4: redirect together with stall at pc 20
    add(1'b0, 1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    fr(32'h80020014, 32'd4);
    for (int k = 2; k < 7; k++) fr(romw[k], 32'(4*k));
    fr(32'h8C140002, 32'd28);
    // T6: reset mid-run
    rs();
    fr(32'h80010028, 32'd0);
    // T5: misaligned redirect, later redirect ignored, reset recovers
    add(1'b0, 1'b0, 1'b1, 32'd6, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, 1'b0, 1'b1, 32'd8, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    rs();
    fr(32'h80010028, 32'd0);
    // aligned target past the ROM halts on the next cycle; misaligned from HALT faults
    add(1'b0, 1'b0, 1'b1, 32'd100, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    add(1'b0, 1'b0, 1'b1, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
    rs();
    fr(32'h80010028, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].stl, tbl[i].red, tbl[i].tgt);
      check($sformatf("row%0d valid", i), {31'd0, valid}, {31'd0, tbl[i].v});
      check($sformatf("row%0d done", i), {31'd0, done}, {31'd0, tbl[i].d});
      check($sformatf("row%0d fault", i), {31'd0, fault}, {31'd0, tbl[i].f});
      if (tbl[i].chk) begin
        check($sformatf("row%0d instr", i), instr, tbl[i].ins);
        check($sformatf("row%0d instr_pc", i), instr_pc, tbl[i].pc);
        check($sformatf("row%0d pc_plus4", i), pc_plus4, tbl[i].pc4);
      end
    end

    // randomized phase with a random ROM, checked against the model
    for (int i = 0; i < NWORDS; i++) romw[i] = $urandom;
    load_rom();
    model_step(1'b1, 1'b0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0);
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_stl, r_red;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 49) == 0);
      r_stl = ($urandom_range(0, 3) == 0);
      r_red = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 7))
        0:       r_tgt = $urandom;
        1:       r_tgt = 32'hFFFF_FFFC;
        2:       r_tgt = 32'd48 + 32'(4 * $urandom_range(0, 3));
        default: r_tgt = 32'(4 * $urandom_range(0, NWORDS - 1));
      endcase
      model_step(r_rst, r_stl, r_red, r_tgt);
      drive(r_rst, r_stl, r_red, r_tgt);
      check($sformatf("rnd%0d valid", n), {31'd0, valid}, {31'd0, e_valid});
      check($sformatf("rnd%0d done", n), {31'd0, done}, {31'd0, m_halted});
      check($sformatf("rnd%0d fault", n), {31'd0, fault}, {31'd0, m_faulted});
      if (m_chk) begin
        check($sformatf("rnd%0d instr", n), instr, e_ins);
        check($sformatf("rnd%0d instr_pc", n), instr_pc, e_pc);
        check($sformatf("rnd%0d pc_plus4", n), pc_plus4, e_pc4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
